// File: rtl/ov9655_cap_pkg.sv
// Shared types and default widths for the OV9655 capture controller.
package ov9655_cap_pkg;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefHcntW = 12;
    localparam int unsigned DefVcntW = 11;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StSync,
        StCapture
    } cap_state_e;

endpackage

// File: rtl/ov9655_edge_det.sv
// Rise/fall detector for one camera sync line (input already synchronised).
module ov9655_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig;
        end
    end

    assign rise = sig & ~prev_q;
    assign fall = ~sig & prev_q;

endmodule

// File: rtl/ov9655_capture_ctrl.sv
// Frame capture sequencer for an OV9655 camera: syncs to VSYNC/HREF, checks
// frame geometry and ping-pongs between two frame-buffer bases.
module ov9655_capture_ctrl
    import ov9655_cap_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned HCNT_W = DefHcntW,
    parameter int unsigned VCNT_W = DefVcntW
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              cfg_continuous,
    input  logic [7:0]        cfg_frame_cnt,
    input  logic [ADDR_W-1:0] cfg_buf_addr0,
    input  logic [ADDR_W-1:0] cfg_buf_addr1,
    input  logic [HCNT_W-1:0] cfg_h_pixels,
    input  logic [VCNT_W-1:0] cfg_v_lines,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              pix_valid,
    output logic              cap_en,
    output logic [ADDR_W-1:0] wr_base,
    output logic              wr_base_valid,
    output logic              frame_done,
    output logic              cur_buf,
    output logic [7:0]        frames_done,
    output logic              busy,
    output logic              err,
    output logic              irq,
    input  logic              irq_clr
);

    cap_state_e        state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic              line_err_q, line_err_d;
    logic              stop_q, stop_d;
    logic [7:0]        frames_q, frames_d;
    logic              cur_buf_q, cur_buf_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic              wbv_q, wbv_d;
    logic              fd_q, fd_d;
    logic              irq_q, irq_d;
    logic              err_q, err_d;
    logic              vs_rise, vs_fall, href_rise_unused, href_fall;
    logic [7:0]        frame_target;

    ov9655_edge_det u_vsync_edge (
        .clk  (ACLK),
        .rst  (ARESET),
        .sig  (cam_vsync),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    ov9655_edge_det u_href_edge (
        .clk  (ACLK),
        .rst  (ARESET),
        .sig  (cam_href),
        .rise (href_rise_unused),
        .fall (href_fall)
    );

    assign frame_target = (cfg_frame_cnt == 8'd0) ? 8'd1 : cfg_frame_cnt;

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        line_err_d = line_err_q;
        stop_d     = stop_q;
        frames_d   = frames_q;
        cur_buf_d  = cur_buf_q;
        wr_base_d  = wr_base_q;
        wbv_d      = 1'b0;
        fd_d       = 1'b0;
        irq_d      = irq_q & ~irq_clr;
        err_d      = err_q & ~irq_clr;

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    state_d   = StArm;
                    frames_d  = 8'd0;
                    cur_buf_d = 1'b0;
                    stop_d    = 1'b0;
                end
            end
            StArm: begin
                if (cfg_stop) begin
                    state_d = StIdle;
                end else if (vs_rise) begin
                    state_d = StSync;
                end
            end
            StSync: begin
                if (cfg_stop) begin
                    state_d = StIdle;
                end else if (vs_fall) begin
                    state_d    = StCapture;
                    wr_base_d  = cur_buf_q ? cfg_buf_addr1 : cfg_buf_addr0;
                    wbv_d      = 1'b1;
                    hcnt_d     = '0;
                    vcnt_d     = '0;
                    line_err_d = 1'b0;
                end
            end
            StCapture: begin
                if (cfg_stop) begin
                    stop_d = 1'b1;
                end
                if (cam_href && pix_valid && hcnt_q != '1) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
                if (href_fall) begin
                    if (vcnt_q != '1) begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                    if (hcnt_q != cfg_h_pixels) begin
                        line_err_d = 1'b1;
                    end
                    hcnt_d = '0;
                end
                // A line ending on the same cycle as VSYNC still counts toward this frame.
                if (vs_rise) begin
                    fd_d  = 1'b1;
                    irq_d = 1'b1;
                    if (frames_q != 8'hff) begin
                        frames_d = frames_q + 8'd1;
                    end
                    if (vcnt_d != cfg_v_lines || line_err_d) begin
                        err_d = 1'b1;
                    end
                    cur_buf_d = ~cur_buf_q;
                    if (!(stop_q || cfg_stop) && (cfg_continuous || frames_d < frame_target)) begin
                        state_d = StSync;
                    end else begin
                        state_d = StIdle;
                    end
                    hcnt_d     = '0;
                    vcnt_d     = '0;
                    line_err_d = 1'b0;
                    stop_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= StIdle;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            line_err_q <= 1'b0;
            stop_q     <= 1'b0;
            frames_q   <= 8'd0;
            cur_buf_q  <= 1'b0;
            wr_base_q  <= '0;
            wbv_q      <= 1'b0;
            fd_q       <= 1'b0;
            irq_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            line_err_q <= line_err_d;
            stop_q     <= stop_d;
            frames_q   <= frames_d;
            cur_buf_q  <= cur_buf_d;
            wr_base_q  <= wr_base_d;
            wbv_q      <= wbv_d;
            fd_q       <= fd_d;
            irq_q      <= irq_d;
            err_q      <= err_d;
        end
    end

    assign cap_en        = (state_q == StCapture);
    assign busy          = (state_q != StIdle);
    assign wr_base       = wr_base_q;
    assign wr_base_valid = wbv_q;
    assign frame_done    = fd_q;
    assign cur_buf       = cur_buf_q;
    assign frames_done   = frames_q;
    assign irq           = irq_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ov9655_capture_ctrl.sv
// Randomised-timing bench for ov9655_capture_ctrl with a queue-based scoreboard.
module tb_ov9655_capture_ctrl;

    localparam logic [31:0] ADDR0 = 32'h1000_0000;
    localparam logic [31:0] ADDR1 = 32'h2000_0000;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0;
    logic [7:0]  cfg_frame_cnt = 8'd2;
    logic [31:0] cfg_buf_addr0 = ADDR0, cfg_buf_addr1 = ADDR1;
    logic [11:0] cfg_h_pixels = 12'd4;
    logic [10:0] cfg_v_lines = 11'd3;
    logic        cam_vsync = 1'b0, cam_href = 1'b0, pix_valid = 1'b0, irq_clr = 1'b0;
    logic        cap_en, wr_base_valid, frame_done, cur_buf, busy, err, irq;
    logic [31:0] wr_base;
    logic [7:0]  frames_done;

    always #5 ACLK = ~ACLK;

    ov9655_capture_ctrl dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_continuous (cfg_continuous),
        .cfg_frame_cnt  (cfg_frame_cnt),
        .cfg_buf_addr0  (cfg_buf_addr0),
        .cfg_buf_addr1  (cfg_buf_addr1),
        .cfg_h_pixels   (cfg_h_pixels),
        .cfg_v_lines    (cfg_v_lines),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .pix_valid      (pix_valid),
        .cap_en         (cap_en),
        .wr_base        (wr_base),
        .wr_base_valid  (wr_base_valid),
        .frame_done     (frame_done),
        .cur_buf        (cur_buf),
        .frames_done    (frames_done),
        .busy           (busy),
        .err            (err),
        .irq            (irq),
        .irq_clr        (irq_clr)
    );

    typedef struct {
        logic [7:0] frames;
        logic       err;
        logic       irq;
        logic       buf_idx;
    } fd_rec_t;

    fd_rec_t     exp_fd[$];
    logic [31:0] exp_base[$];
    fd_rec_t     mon_rec;
    int          n_checks = 0;
    int          n_fail = 0;

    // Reference model state: what software would observe, frame by frame.
    int   mdl_frames = 0;
    logic mdl_buf = 1'b0;
    logic mdl_err = 1'b0;
    logic mdl_irq = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    always @(negedge ACLK) begin
        if (wr_base_valid) begin
            if (exp_base.size() == 0) begin
                chk("wr_base_valid_unexpected", {63'd0, wr_base_valid}, 64'd0);
            end else begin
                chk("wr_base", {32'd0, wr_base}, {32'd0, exp_base.pop_front()});
            end
        end
        if (frame_done) begin
            if (exp_fd.size() == 0) begin
                chk("frame_done_unexpected", {63'd0, frame_done}, 64'd0);
            end else begin
                mon_rec = exp_fd.pop_front();
                chk("frames_done", {56'd0, frames_done}, {56'd0, mon_rec.frames});
                chk("err_at_frame_end", {63'd0, err}, {63'd0, mon_rec.err});
                chk("irq_at_frame_end", {63'd0, irq}, {63'd0, mon_rec.irq});
                chk("cur_buf_after_frame", {63'd0, cur_buf}, {63'd0, mon_rec.buf_idx});
            end
        end
    end

    task automatic start_seq();
        cam_vsync = 1'b0;
        repeat (3) tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        mdl_frames = 0;
        mdl_buf = 1'b0;
        cam_vsync = 1'b1;
        tick();
    endtask

    // One frame body: VSYNC already high on entry, high again on exit.
    task automatic body(input int lines, input int hpix, input int bad_line, input int bad_len,
                        input bit cap, input bit start_mid, input int stop_line,
                        input bit clr_at_end);
        logic    frame_bad;
        bit      stop_sent;
        fd_rec_t r;
        stop_sent = 1'b0;
        if (cap) exp_base.push_back(mdl_buf ? ADDR1 : ADDR0);
        repeat (3) tick();
        cam_vsync = 1'b0;
        tick();
        if (start_mid) begin
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
            mdl_frames = 0;
            mdl_buf = 1'b0;
        end else begin
            tick();
        end
        chk("cap_en_in_frame", {63'd0, cap_en}, {63'd0, cap});
        for (int l = 0; l < lines; l++) begin
            int n;
            int got;
            n = (l == bad_line) ? bad_len : hpix;
            got = 0;
            cam_href = 1'b1;
            while (got < n) begin
                pix_valid = ($urandom_range(0, 3) != 0);
                if (pix_valid) got++;
                if (l == stop_line && !stop_sent) begin
                    cfg_stop = 1'b1;
                    stop_sent = 1'b1;
                end
                tick();
                cfg_stop = 1'b0;
            end
            cam_href = 1'b0;
            pix_valid = 1'($urandom_range(0, 1));
            tick();
            pix_valid = 1'b0;
            tick();
        end
        tick();
        if (cap) begin
            frame_bad = (lines != int'(cfg_v_lines)) || (hpix != int'(cfg_h_pixels)) ||
                        (bad_line >= 0 && bad_line < lines && bad_len != hpix);
            mdl_frames = (mdl_frames >= 255) ? 255 : mdl_frames + 1;
            if (clr_at_end) mdl_err = 1'b0;
            mdl_err = mdl_err | frame_bad;
            mdl_irq = 1'b1;
            mdl_buf = ~mdl_buf;
            r.frames = 8'(mdl_frames);
            r.err = mdl_err;
            r.irq = mdl_irq;
            r.buf_idx = mdl_buf;
            exp_fd.push_back(r);
        end
        cam_vsync = 1'b1;
        irq_clr = clr_at_end;
        tick();
        irq_clr = 1'b0;
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_cap_en"}, {63'd0, cap_en}, 64'd0);
        chk({tag, "_wr_base"}, {32'd0, wr_base}, 64'd0);
        chk({tag, "_wr_base_valid"}, {63'd0, wr_base_valid}, 64'd0);
        chk({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
        chk({tag, "_cur_buf"}, {63'd0, cur_buf}, 64'd0);
        chk({tag, "_frames_done"}, {56'd0, frames_done}, 64'd0);
        chk({tag, "_irq"}, {63'd0, irq}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    initial begin
        repeat (2) tick();
        chk_reset_outputs("reset");
        ARESET = 1'b0;
        tick();

        // Two 4x3 frames into alternating buffers.
        start_seq();
        body(3, 4, -1, 0, 1'b1, 1'b0, -1, 1'b0);
        body(3, 4, -1, 0, 1'b1, 1'b0, -1, 1'b0);
        chk("idle_after_two_frames", {63'd0, busy}, 64'd0);
        chk("frames_done_two", {56'd0, frames_done}, 64'd2);
        chk("err_after_two", {63'd0, err}, 64'd0);

        // Start mid-frame: that partial frame must be skipped.
        cfg_frame_cnt = 8'd1;
        body(3, 4, -1, 0, 1'b0, 1'b1, -1, 1'b0);
        body(3, 4, -1, 0, 1'b1, 1'b0, -1, 1'b0);
        chk("idle_after_mid_start", {63'd0, busy}, 64'd0);

        // Short second line flags a geometry error.
        start_seq();
        body(3, 4, 1, 3, 1'b1, 1'b0, -1, 1'b0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        mdl_irq = 1'b0;
        mdl_err = 1'b0;
        chk("irq_cleared", {63'd0, irq}, 64'd0);
        chk("err_cleared", {63'd0, err}, 64'd0);

        // Continuous run past the frames_done saturation point, then stop mid-frame.
        cfg_continuous = 1'b1;
        cfg_h_pixels = 12'd2;
        cfg_v_lines = 11'd1;
        start_seq();
        for (int f = 0; f < 300; f++) body(1, 2, -1, 0, 1'b1, 1'b0, -1, 1'b0);
        body(1, 2, -1, 0, 1'b1, 1'b0, 0, 1'b0);
        chk("idle_after_stop", {63'd0, busy}, 64'd0);
        chk("frames_done_saturated", {56'd0, frames_done}, 64'd255);

        // Stop while waiting in SYNC.
        cfg_continuous = 1'b0;
        cfg_frame_cnt = 8'd0;
        cfg_h_pixels = 12'd4;
        cfg_v_lines = 11'd3;
        start_seq();
        chk("busy_in_sync", {63'd0, busy}, 64'd1);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        chk("idle_after_sync_stop", {63'd0, busy}, 64'd0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        mdl_irq = 1'b0;
        chk("irq_cleared_again", {63'd0, irq}, 64'd0);

        // irq_clr on the frame-end cycle loses to the frame-end set.
        start_seq();
        body(3, 4, -1, 0, 1'b1, 1'b0, -1, 1'b1);
        chk("irq_set_wins", {63'd0, irq}, 64'd1);
        chk("idle_frame_cnt_zero", {63'd0, busy}, 64'd0);

        // Reset in the middle of a capture.
        cfg_continuous = 1'b1;
        start_seq();
        exp_base.push_back(ADDR0);
        repeat (3) tick();
        cam_vsync = 1'b0;
        tick();
        tick();
        chk("cap_en_before_abort", {63'd0, cap_en}, 64'd1);
        cam_href = 1'b1;
        pix_valid = 1'b1;
        repeat (2) tick();
        ARESET = 1'b1;
        tick();
        chk_reset_outputs("abort");
        ARESET = 1'b0;
        cam_href = 1'b0;
        pix_valid = 1'b0;
        mdl_irq = 1'b0;
        mdl_err = 1'b0;
        repeat (2) tick();
        cam_vsync = 1'b1;
        repeat (4) tick();
        chk("idle_after_abort", {63'd0, busy}, 64'd0);

        chk("base_queue_drained", 64'(exp_base.size()), 64'd0);
        chk("frame_queue_drained", 64'(exp_fd.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
